// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and bus accesses onto one single-port data RAM.
// Writes finish in their grant cycle. A read holds the RAM for RD_LAT wait cycles and then one response cycle.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [15:0]       bus_wdata,
    output logic              bus_gnt,
    output logic [15:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_rden,
    input  logic [15:0]       mem_q
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        owner_q, owner_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] bus_rdata_q, bus_rdata_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        bus_rvalid_q, bus_rvalid_d;

    logic issue_ok;
    logic gnt_cpu;
    logic gnt_bus;

    // last_gnt_q / owner_q: 1 means the bus. A tie goes to the side that did not win last time.
    assign issue_ok = (state_q == IDLE) && rst_n;
    assign gnt_cpu  = issue_ok && cpu_req && (!bus_req || last_gnt_q);
    assign gnt_bus  = issue_ok && bus_req && (!cpu_req || !last_gnt_q);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_rden  = 1'b0;
        if (gnt_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_rden  = !cpu_we;
        end else if (gnt_bus) begin
            mem_addr  = bus_addr;
            mem_wdata = bus_wdata;
            mem_we    = bus_we;
            mem_rden  = !bus_we;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_gnt_d   = last_gnt_q;
        owner_d      = owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        bus_rdata_d  = bus_rdata_q;
        cpu_rvalid_d = 1'b0;
        bus_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_cpu || gnt_bus) begin
                    last_gnt_d = gnt_bus;
                    if (mem_rden) begin
                        state_d = WAIT;
                        cnt_d   = LAT_LAST;
                        owner_d = gnt_bus;
                    end
                end
            end
            WAIT: begin
                // mem_q is valid during the last wait cycle. It is captured on that cycle's closing edge.
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    if (owner_q) begin
                        bus_rdata_d  = mem_q;
                        bus_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_q;
                        cpu_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_gnt_q   <= 1'b1;
            owner_q      <= 1'b0;
            cpu_rdata_q  <= 16'h0000;
            bus_rdata_q  <= 16'h0000;
            cpu_rvalid_q <= 1'b0;
            bus_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_gnt_q   <= last_gnt_d;
            owner_q      <= owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            bus_rdata_q  <= bus_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            bus_rvalid_q <= bus_rvalid_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign bus_rdata  = bus_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign bus_rvalid = bus_rvalid_q;
    assign bus_gnt    = gnt_bus;
    assign cpu_stall  = cpu_req && !(gnt_cpu && cpu_we) && !cpu_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A latency-1 instance runs directed and random traffic against a transaction-level model.
// A latency-3 instance is used for the long-latency bus read.
module tb_dmem_arbiter;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n;

    logic        cpuReq, cpuWe, busReq, busWe;
    logic [7:0]  cpuAddr, busAddr;
    logic [15:0] cpuWdata, busWdata;
    logic [15:0] cpuRdata, busRdata;
    logic        cpuRvalid, cpuStall, busGnt, busRvalid;
    logic [7:0]  memAddr;
    logic [15:0] memWdata, memQ;
    logic        memWe, memRden;

    logic        busReq3, busWe3;
    logic [7:0]  busAddr3;
    logic [15:0] busWdata3;
    logic [15:0] cpuRdata3, busRdata3;
    logic        cpuRvalid3, cpuStall3, busGnt3, busRvalid3;
    logic [7:0]  memAddr3;
    logic [15:0] memWdata3, memQ3;
    logic        memWe3, memRden3;

    logic [15:0] ramMem [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] refMem [256];
    logic        mLastBus;
    int          mRvAt;
    int          mFreeAt;
    logic        mRvPort;
    logic [15:0] mRvData, mCpuRdata, mBusRdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata), .cpu_rvalid(cpuRvalid), .cpu_stall(cpuStall),
        .bus_req(busReq), .bus_we(busWe), .bus_addr(busAddr), .bus_wdata(busWdata),
        .bus_gnt(busGnt), .bus_rdata(busRdata), .bus_rvalid(busRvalid),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe), .mem_rden(memRden), .mem_q(memQ)
    );

    dmem_arbiter #(.ADDR_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(8'h00), .cpu_wdata(16'h0000),
        .cpu_rdata(cpuRdata3), .cpu_rvalid(cpuRvalid3), .cpu_stall(cpuStall3),
        .bus_req(busReq3), .bus_we(busWe3), .bus_addr(busAddr3), .bus_wdata(busWdata3),
        .bus_gnt(busGnt3), .bus_rdata(busRdata3), .bus_rvalid(busRvalid3),
        .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_we(memWe3), .mem_rden(memRden3), .mem_q(memQ3)
    );

    function automatic logic [15:0] memInit(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a ^ 8'hC3, ~a};
    endfunction

    function automatic logic [7:0] randAddr();
        return ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
    endfunction

    // The RAM model delivers read data only in the cycle it is due. Every other cycle it shows random junk.
    assign memQ  = pipe1;
    assign memQ3 = pipe3[2];
    initial begin
        for (int i = 0; i < 256; i++) ramMem[i] = memInit(8'(i));
        forever begin
            @(posedge clk);
            if (memWe) ramMem[memAddr] <= memWdata;
            pipe1    <= memRden ? ramMem[memAddr] : 16'($urandom);
            pipe3[0] <= memRden3 ? ramMem[memAddr3] : 16'($urandom);
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic cReq, input logic cWe,
                                 input logic [7:0] cAddr, input logic [15:0] cWd,
                                 input logic bReq, input logic bWe,
                                 input logic [7:0] bAddr, input logic [15:0] bWd);
        @(negedge clk);
        rst_n    = rst;
        cpuReq   = cReq;
        cpuWe    = cWe;
        cpuAddr  = cAddr;
        cpuWdata = cWd;
        busReq   = bReq;
        busWe    = bWe;
        busAddr  = bAddr;
        busWdata = bWd;
    endtask

    // Transaction model: a read granted in cycle t answers at t+LAT+1, and the RAM is free again at t+LAT+2.
    task automatic modelCheck();
        logic free, gC, gB, expCpuRv, expBusRv, expWe, expRden, expStall;
        logic [7:0]  expAddr;
        logic [15:0] expWd;
        if (!rst_n) begin
            mLastBus  = 1'b1;
            mRvAt     = -1;
            mFreeAt   = 0;
            mCpuRdata = 16'h0000;
            mBusRdata = 16'h0000;
        end
        free = rst_n && (cyc >= mFreeAt);
        gC = free && cpuReq && (!busReq || mLastBus);
        gB = free && busReq && (!cpuReq || !mLastBus);
        expWe = 1'b0; expRden = 1'b0; expAddr = 8'h00; expWd = 16'h0000;
        if (gC) begin
            expAddr = cpuAddr; expWd = cpuWdata; expWe = cpuWe; expRden = !cpuWe;
        end else if (gB) begin
            expAddr = busAddr; expWd = busWdata; expWe = busWe; expRden = !busWe;
        end
        expCpuRv = rst_n && (cyc == mRvAt) && !mRvPort;
        expBusRv = rst_n && (cyc == mRvAt) && mRvPort;
        if (expCpuRv) mCpuRdata = mRvData;
        if (expBusRv) mBusRdata = mRvData;
        expStall = cpuReq && !(gC && cpuWe) && !expCpuRv;
        checkOutput("mem_addr",   32'(memAddr),   32'(expAddr));
        checkOutput("mem_wdata",  32'(memWdata),  32'(expWd));
        checkOutput("mem_we",     32'(memWe),     32'(expWe));
        checkOutput("mem_rden",   32'(memRden),   32'(expRden));
        checkOutput("bus_gnt",    32'(busGnt),    32'(gB));
        checkOutput("cpu_rvalid", 32'(cpuRvalid), 32'(expCpuRv));
        checkOutput("bus_rvalid", 32'(busRvalid), 32'(expBusRv));
        checkOutput("cpu_rdata",  32'(cpuRdata),  32'(mCpuRdata));
        checkOutput("bus_rdata",  32'(busRdata),  32'(mBusRdata));
        checkOutput("cpu_stall",  32'(cpuStall),  32'(expStall));
        if (gC || gB) begin
            mLastBus = gB;
            if (expWe) begin
                refMem[expAddr] = expWd;
            end else begin
                mRvPort = gB;
                mRvData = refMem[expAddr];
                mRvAt   = cyc + LAT + 1;
                mFreeAt = cyc + LAT + 2;
            end
        end
        cyc++;
    endtask

    task automatic runCycle(input logic rst, input logic cReq, input logic cWe,
                            input logic [7:0] cAddr, input logic [15:0] cWd,
                            input logic bReq, input logic bWe,
                            input logic [7:0] bAddr, input logic [15:0] bWd);
        applyStimulus(rst, cReq, cWe, cAddr, cWd, bReq, bWe, bAddr, bWd);
        #1;
        modelCheck();
    endtask

    task automatic idleCycle();
        runCycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = memInit(8'(i));
        mLastBus = 1'b1; mRvAt = -1; mFreeAt = 0; mRvPort = 1'b0;
        mRvData = 16'h0000; mCpuRdata = 16'h0000; mBusRdata = 16'h0000;
        rst_n = 1'b0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 8'h00; cpuWdata = 16'h0000;
        busReq = 1'b0; busWe = 1'b0; busAddr = 8'h00; busWdata = 16'h0000;
        busReq3 = 1'b0; busWe3 = 1'b0; busAddr3 = 8'h00; busWdata3 = 16'h0000;

        // Reset state.
        runCycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        runCycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("rst_cpu_rdata", 32'(cpuRdata), 32'h0);
        checkOutput("rst_mem_rden", 32'(memRden), 32'h0);
        idleCycle();

        // Simultaneous writes straight after reset: the CPU wins the first tie.
        runCycle(1'b1, 1'b1, 1'b1, 8'h30, 16'h1111, 1'b1, 1'b1, 8'h31, 16'h2222);
        checkOutput("tie_cpu_stall", 32'(cpuStall), 32'h0);
        checkOutput("tie_bus_gnt", 32'(busGnt), 32'h0);
        checkOutput("tie_addr", 32'(memAddr), 32'h30);
        runCycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h31, 16'h2222);
        checkOutput("tie_bus_gnt_next", 32'(busGnt), 32'h1);
        checkOutput("tie_addr_next", 32'(memAddr), 32'h31);
        idleCycle();

        // CPU read of 0x10, answered two cycles later.
        runCycle(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("rd_rden_t", 32'(memRden), 32'h1);
        checkOutput("rd_stall_t", 32'(cpuStall), 32'h1);
        runCycle(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("rd_stall_t1", 32'(cpuStall), 32'h1);
        runCycle(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("rd_rvalid_t2", 32'(cpuRvalid), 32'h1);
        checkOutput("rd_rdata_t2", 32'(cpuRdata), 32'hBEEF);
        checkOutput("rd_stall_t2", 32'(cpuStall), 32'h0);
        idleCycle();

        // A bus write makes the CPU the favoured side for the following tie.
        runCycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h42, 16'h3333);
        idleCycle();

        // Both sides read continuously, so grants alternate CPU, bus, CPU.
        for (int k = 0; k < 9; k++) begin
            runCycle(1'b1, 1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 8'h41, 16'h0000);
            checkOutput("alt_rden", 32'(memRden), 32'(k % 3 == 0));
            if (k % 3 == 0) checkOutput("alt_addr", 32'(memAddr), (k == 3) ? 32'h41 : 32'h40);
            checkOutput("alt_cpu_rv", 32'(cpuRvalid), 32'(k == 2 || k == 8));
            checkOutput("alt_bus_rv", 32'(busRvalid), 32'(k == 5));
        end
        idleCycle();

        // A bus request dropped while the CPU holds the RAM never reaches memory.
        runCycle(1'b1, 1'b1, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        runCycle(1'b1, 1'b1, 1'b0, 8'h50, 16'h0000, 1'b1, 1'b1, 8'h51, 16'h7777);
        checkOutput("drop_gnt_wait", 32'(busGnt), 32'h0);
        checkOutput("drop_we_wait", 32'(memWe), 32'h0);
        runCycle(1'b1, 1'b1, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        idleCycle();
        checkOutput("drop_gnt_idle", 32'(busGnt), 32'h0);
        checkOutput("drop_ram", 32'(ramMem[8'h51]), 32'(memInit(8'h51)));

        // Reset during WAIT: the read is aborted and a later read completes.
        runCycle(1'b1, 1'b1, 1'b0, 8'h60, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        runCycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrst_rvalid", 32'(cpuRvalid), 32'h0);
        checkOutput("wrst_cpu_rdata", 32'(cpuRdata), 32'h0);
        checkOutput("wrst_bus_rdata", 32'(busRdata), 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrst_rvalid2", 32'(cpuRvalid), 32'h0);
        runCycle(1'b1, 1'b1, 1'b0, 8'h61, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrst_new_rden", 32'(memRden), 32'h1);
        checkOutput("wrst_new_addr", 32'(memAddr), 32'h61);
        runCycle(1'b1, 1'b1, 1'b0, 8'h61, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        runCycle(1'b1, 1'b1, 1'b0, 8'h61, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrst_new_rvalid", 32'(cpuRvalid), 32'h1);
        checkOutput("wrst_new_rdata", 32'(cpuRdata), 32'(memInit(8'h61)));
        idleCycle();

        // Latency-3 instance: a bus read granted at t answers at t+4.
        for (int k = 0; k < 6; k++) begin
            idleCycle();
            busReq3   = (k < 5);
            busWe3    = 1'b0;
            busAddr3  = 8'h20;
            busWdata3 = 16'h1234;
            #1;
            checkOutput("l3_gnt", 32'(busGnt3), 32'(k == 0));
            checkOutput("l3_rden", 32'(memRden3), 32'(k == 0));
            checkOutput("l3_rvalid", 32'(busRvalid3), 32'(k == 4));
            if (k == 0) begin
                checkOutput("l3_addr", 32'(memAddr3), 32'h20);
                checkOutput("l3_wdata", 32'(memWdata3), 32'h1234);
            end
            if (k >= 4) checkOutput("l3_rdata", 32'(busRdata3), 32'(memInit(8'h20)));
        end
        checkOutput("l3_cpu_idle", 32'({cpuRvalid3, cpuStall3, memWe3}), 32'h0);
        checkOutput("l3_cpu_rdata", 32'(cpuRdata3), 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            runCycle($urandom_range(0, 99) != 0,
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), randAddr(), 16'($urandom),
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), randAddr(), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
